// File: rtl/div16_iter_pkg.sv
// div16_iter_pkg: shared definitions for the iterative 16-bit divider.
//   state_t    - FSM state encoding (IDLE/RUN/SIGN/DONE)
//   DIV_ITERS  - restoring steps per division
//   DIV_ZERO_Q - quotient reported on divide-by-zero
//   mag16()    - magnitude of a 16-bit operand when signed, else pass-through
package div16_iter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      SIGN = 2'b10,
      DONE = 2'b11
   } state_t;

   localparam int          DIV_ITERS  = 16;
   localparam logic [15:0] DIV_ZERO_Q = 16'hFFFF;

   // |0x8000| stays 0x8000 and is then treated as an unsigned magnitude.
   function automatic logic [15:0] mag16(input logic [15:0] v, input logic is_signed);
      if (is_signed && v[15]) begin
         return (~v) + 16'd1;
      end
      return v;
   endfunction

endpackage

// File: rtl/div16_iter_step.sv
// div16_iter_step: one combinational restoring-division step.
//   p      - 17-bit partial remainder in
//   q      - 16-bit dividend/quotient shift register in
//   d      - 16-bit divisor magnitude
//   p_nxt  - partial remainder after the step
//   q_nxt  - shift register after the step (new quotient bit in LSB)
module div16_iter_step (
   input  logic [16:0] p,
   input  logic [15:0] q,
   input  logic [15:0] d,
   output logic [16:0] p_nxt,
   output logic [15:0] q_nxt
);

   logic [16:0] shifted;
   logic [16:0] trial;

   always_comb begin
      shifted = {p[15:0], q[15]};
      trial   = shifted - {1'b0, d};
      // A clear borrow bit means the divisor fit: keep the difference.
      if (!trial[16]) begin
         p_nxt = trial;
         q_nxt = {q[14:0], 1'b1};
      end else begin
         p_nxt = shifted;
         q_nxt = {q[14:0], 1'b0};
      end
   end

endmodule

// File: rtl/div16_iter.sv
// div16_iter: multi-cycle signed/unsigned 16-bit restoring divider.
//   clk, rst     - clock; synchronous active-low reset
//   start        - request, sampled only in IDLE together with operands
//   signed_op    - 1 = two's-complement divide, 0 = unsigned
//   dividend     - numerator
//   divisor      - denominator
//   busy         - high whenever the FSM is not IDLE
//   done         - one-cycle pulse; results valid and held afterwards
//   quotient     - registered quotient
//   remainder    - registered remainder (sign follows dividend)
//   div_by_zero  - registered divide-by-zero flag
//   ofl          - registered signed overflow flag (0x8000 / 0xFFFF)
// Handshake: start is a single-cycle request accepted only while busy is
// low; while busy is high start is ignored, and the pipeline captures
// results in the cycle done is high.
module div16_iter
   import div16_iter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int ITERS = DIV_ITERS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             ofl
);

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic [16:0] p_r;
   logic [15:0] q_r, d_r;
   logic [15:0] a_r, b_r;
   logic        sop_r, neg_q, neg_r;
   logic [16:0] p_nxt;
   logic [15:0] q_nxt;
   logic        ofl_case;

   div16_iter_step u_step (
      .p     (p_r),
      .q     (q_r),
      .d     (d_r),
      .p_nxt (p_nxt),
      .q_nxt (q_nxt)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = (divisor == '0) ? DONE : RUN;
         RUN:  if (cnt == 4'(ITERS - 1)) state_nxt = SIGN;
         SIGN: state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // Overflow is judged on the latched raw operands, not the magnitudes.
   assign ofl_case = sop_r && (a_r == 16'h8000) && (b_r == 16'hFFFF);

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt         <= '0;
         p_r         <= '0;
         q_r         <= '0;
         d_r         <= '0;
         a_r         <= '0;
         b_r         <= '0;
         sop_r       <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         ofl         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_r   <= dividend;
                  b_r   <= divisor;
                  sop_r <= signed_op;
                  if (divisor == '0) begin
                     quotient    <= DIV_ZERO_Q;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     ofl         <= 1'b0;
                  end else begin
                     q_r   <= mag16(dividend, signed_op);
                     d_r   <= mag16(divisor, signed_op);
                     p_r   <= '0;
                     cnt   <= '0;
                     neg_q <= signed_op & (dividend[15] ^ divisor[15]);
                     neg_r <= signed_op & dividend[15];
                  end
               end
            end
            RUN: begin
               p_r <= p_nxt;
               q_r <= q_nxt;
               cnt <= cnt + 4'd1;
            end
            SIGN: begin
               div_by_zero <= 1'b0;
               ofl         <= ofl_case;
               if (ofl_case) begin
                  quotient  <= 16'h8000;
                  remainder <= 16'h0000;
               end else begin
                  quotient  <= neg_q ? (~q_r) + 16'd1 : q_r;
                  remainder <= neg_r ? (~p_r[15:0]) + 16'd1 : p_r[15:0];
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div16_iter.sv
// tb_div16_iter: directed self-checking bench for div16_iter.
module tb_div16_iter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        signed_op = 1'b0;
   logic [15:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic        busy, done;
   logic [15:0] quotient, remainder;
   logic        div_by_zero, ofl;

   int total = 0;
   int bad = 0;

   div16_iter dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .signed_op   (signed_op),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .ofl         (ofl)
   );

   always #5 clk = ~clk;

   // Advance past one rising edge; outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one division; lat = edge after which done must be high,
   // inj = edge at which a stray start is pulsed (-1 = none).
   task automatic do_div(input string tag, input logic sop,
                         input logic [15:0] a, input logic [15:0] b,
                         input int lat, input int inj,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic edz, input logic eofl);
      int first_done;
      int n_done;
      int busy_bad;
      first_done = -1;
      n_done     = 0;
      busy_bad   = 0;
      signed_op  = sop;
      dividend   = a;
      divisor    = b;
      start      = 1'b1;
      tick();
      start     = 1'b0;
      dividend  = ~a;
      divisor   = b ^ 16'h5A5A;
      signed_op = ~sop;
      if (done) begin
         n_done++;
         first_done = 0;
      end
      if (!busy) busy_bad++;
      for (int e = 1; e <= lat + 3; e++) begin
         if (e == inj) begin
            start    = 1'b1;
            dividend = 16'h0010;
            divisor  = 16'h0004;
         end
         tick();
         start = 1'b0;
         if (done) begin
            n_done++;
            if (first_done < 0) first_done = e;
         end
         if (e <= lat && !busy) busy_bad++;
         if (e == lat + 1) chk({tag, ".busy_after"}, 32'(busy), 32'd0);
      end
      chk({tag, ".done_edge"}, first_done, lat);
      chk({tag, ".done_count"}, n_done, 1);
      chk({tag, ".busy_during"}, busy_bad, 0);
      chk({tag, ".quotient"}, 32'(quotient), 32'(eq));
      chk({tag, ".remainder"}, 32'(remainder), 32'(er));
      chk({tag, ".div_by_zero"}, 32'(div_by_zero), 32'(edz));
      chk({tag, ".ofl"}, 32'(ofl), 32'(eofl));
   endtask

   initial begin
      int n_done;
      rst = 1'b0;
      tick();
      tick();
      chk("reset.busy", 32'(busy), 32'd0);
      chk("reset.done", 32'(done), 32'd0);
      chk("reset.quotient", 32'(quotient), 32'd0);
      chk("reset.remainder", 32'(remainder), 32'd0);
      chk("reset.flags", {30'd0, div_by_zero, ofl}, 32'd0);
      rst = 1'b1;
      tick();

      do_div("u100_7", 1'b0, 16'h0064, 16'h0007, 17, -1, 16'h000E, 16'h0002, 1'b0, 1'b0);
      do_div("u100_7_inj", 1'b0, 16'h0064, 16'h0007, 17, 5, 16'h000E, 16'h0002, 1'b0, 1'b0);
      do_div("s_m7_2", 1'b1, 16'hFFF9, 16'h0002, 17, -1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
      do_div("s_7_m2", 1'b1, 16'h0007, 16'hFFFE, 17, -1, 16'hFFFD, 16'h0001, 1'b0, 1'b0);
      do_div("dz", 1'b0, 16'h04D2, 16'h0000, 0, -1, 16'hFFFF, 16'h04D2, 1'b1, 1'b0);
      do_div("u_ffff_1", 1'b0, 16'hFFFF, 16'h0001, 17, -1, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
      do_div("s_ofl", 1'b1, 16'h8000, 16'hFFFF, 17, -1, 16'h8000, 16'h0000, 1'b0, 1'b1);
      do_div("u_8000_ffff", 1'b0, 16'h8000, 16'hFFFF, 17, -1, 16'h0000, 16'h8000, 1'b0, 1'b0);
      do_div("s_m100_7", 1'b1, 16'hFF9C, 16'h0007, 17, -1, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0);

      // Reset in the middle of a RUN discards the operation.
      signed_op = 1'b0;
      dividend  = 16'h0064;
      divisor   = 16'h0007;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int e = 1; e <= 7; e++) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("midrst.busy", 32'(busy), 32'd0);
      chk("midrst.done", 32'(done), 32'd0);
      chk("midrst.quotient", 32'(quotient), 32'd0);
      chk("midrst.remainder", 32'(remainder), 32'd0);
      chk("midrst.flags", {30'd0, div_by_zero, ofl}, 32'd0);
      n_done = 0;
      for (int e = 0; e < 25; e++) begin
         tick();
         if (done) n_done++;
      end
      chk("midrst.no_done", n_done, 0);

      do_div("u9_3", 1'b0, 16'h0009, 16'h0003, 17, -1, 16'h0003, 16'h0000, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
